// File: rtl/mod_reduce_128_pkg.sv
// Shared widths and FSM state encoding for the ElGamal modular-arithmetic blocks.
package mod_reduce_128_pkg;
   localparam int PROD_W = 128;
   localparam int KEY_W  = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mod_reduce_128_sub_step.sv
// One restoring-reduction step: shift in one dividend bit, subtract p when the result reaches p.
module mod_reduce_128_sub_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] r,
   input  logic         bit_in,
   input  logic [W-1:0] p,
   output logic [W-1:0] r_next
);
   logic [W:0]   shifted;
   logic [W-1:0] diff;

   assign shifted = {r, bit_in};
   // r < p on entry, so shifted - p < p fits in W bits; the dropped top bit cancels out.
   assign diff    = shifted[W-1:0] - p;
   assign r_next  = (shifted >= {1'b0, p}) ? diff : shifted[W-1:0];
endmodule

// File: rtl/mod_reduce_128.sv
// Sequential modular reducer: remainder of a WIDTH_IN-bit product by a WIDTH_M-bit modulus,
// one dividend bit per clock, valid/ready on the product, modulus and result streams.
module mod_reduce_128
   import mod_reduce_128_pkg::*;
#(
   parameter int WIDTH_IN = PROD_W,
   parameter int WIDTH_M  = KEY_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH_IN-1:0] input_tdata,
   input  logic                input_tvalid,
   output logic                input_tready,
   input  logic [WIDTH_M-1:0]  modulus_tdata,
   input  logic                modulus_tvalid,
   output logic                modulus_tready,
   output logic [WIDTH_M-1:0]  output_tdata,
   output logic                output_tuser,
   output logic                output_tvalid,
   input  logic                output_tready,
   output state_t              dbg_state
);
   // Handshake: a transfer happens on a rising edge where tvalid and tready are both 1;
   // the producer holds tdata stable while tvalid is 1 and tready is 0.
   localparam int CNT_W = $clog2(WIDTH_IN);

   state_t              state;
   logic [WIDTH_IN-1:0] a_q;
   logic [WIDTH_M-1:0]  p_q;
   logic [WIDTH_M-1:0]  r_q;
   logic [WIDTH_M-1:0]  r_next;
   logic [CNT_W-1:0]    cnt_q;
   logic                a_held;
   logic                m_held;
   logic                a_fire;
   logic                m_fire;

   assign input_tready   = ~rst & (state == ST_IDLE) & ~a_held;
   assign modulus_tready = ~rst & (state == ST_IDLE) & ~m_held;
   assign a_fire         = input_tvalid & input_tready;
   assign m_fire         = modulus_tvalid & modulus_tready;
   assign dbg_state      = state;

   mod_reduce_128_sub_step #(.W(WIDTH_M)) u_step (
      .r      (r_q),
      .bit_in (a_q[cnt_q]),
      .p      (p_q),
      .r_next (r_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         a_q           <= '0;
         p_q           <= '0;
         r_q           <= '0;
         cnt_q         <= '0;
         a_held        <= 1'b0;
         m_held        <= 1'b0;
         output_tdata  <= '0;
         output_tuser  <= 1'b0;
         output_tvalid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (a_fire) begin
                  a_q    <= input_tdata;
                  a_held <= 1'b1;
               end
               if (m_fire) begin
                  p_q    <= modulus_tdata;
                  m_held <= 1'b1;
               end
               if (a_held && m_held) begin
                  if (p_q == '0) begin
                     state         <= ST_DONE;
                     output_tdata  <= '0;
                     output_tuser  <= 1'b1;
                     output_tvalid <= 1'b1;
                  end else begin
                     state <= ST_CALC;
                     r_q   <= '0;
                     cnt_q <= CNT_W'(WIDTH_IN - 1);
                  end
               end
            end
            ST_CALC: begin
               r_q <= r_next;
               if (cnt_q == '0) begin
                  state         <= ST_DONE;
                  output_tdata  <= r_next;
                  output_tuser  <= 1'b0;
                  output_tvalid <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (output_tready) begin
                  state         <= ST_IDLE;
                  output_tvalid <= 1'b0;
                  a_held        <= 1'b0;
                  m_held        <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mod_reduce_128.sv
// Bench for mod_reduce_128: directed vector table, timing/backpressure/reset sequences, random pairs.
module tb_mod_reduce_128;
   import mod_reduce_128_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] input_tdata = '0;
   logic         input_tvalid = 1'b0;
   logic         input_tready;
   logic [63:0]  modulus_tdata = '0;
   logic         modulus_tvalid = 1'b0;
   logic         modulus_tready;
   logic [63:0]  output_tdata;
   logic         output_tuser;
   logic         output_tvalid;
   logic         output_tready = 1'b0;
   state_t       dbg_state;

   mod_reduce_128 dut (
      .clk            (clk),
      .rst            (rst),
      .input_tdata    (input_tdata),
      .input_tvalid   (input_tvalid),
      .input_tready   (input_tready),
      .modulus_tdata  (modulus_tdata),
      .modulus_tvalid (modulus_tvalid),
      .modulus_tready (modulus_tready),
      .output_tdata   (output_tdata),
      .output_tuser   (output_tuser),
      .output_tvalid  (output_tvalid),
      .output_tready  (output_tready),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cap_a_cyc, cap_m_cyc, rise_cyc;
   int n_xfer   = 0;
   int ready_ctl = 0;  // 0 low, 1 high, 2 random
   logic [64:0] exp_q[$];
   logic [63:0] last_data;
   logic        last_user;
   logic        prev_tvalid = 1'b0;
   logic        hold_pending = 1'b0;
   logic [64:0] hold_val;

   typedef struct {
      logic [127:0] a;
      logic [63:0]  p;
      logic [63:0]  exp_data;
      logic         exp_user;
      int           exp_lat;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [64:0] model(input logic [127:0] a, input logic [63:0] p);
      logic [127:0] rem;
      if (p == 64'd0) return {1'b1, 64'd0};
      rem = a % {64'd0, p};
      return {1'b0, rem[63:0]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (ready_ctl)
         0:       output_tready = 1'b0;
         1:       output_tready = 1'b1;
         default: output_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Result monitor: capture timestamps, scoreboard transfers, hold-stability under backpressure.
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
         prev_tvalid  = 1'b0;
      end else begin
         if (input_tvalid && input_tready) cap_a_cyc = cyc + 1;
         if (modulus_tvalid && modulus_tready) cap_m_cyc = cyc + 1;
         if (output_tvalid && !prev_tvalid) rise_cyc = cyc;
         if (hold_pending) begin
            check("hold_valid", 128'(output_tvalid), 128'd1);
            check("hold_data", 128'({output_tuser, output_tdata}), 128'(hold_val));
         end
         if (output_tvalid && output_tready) begin
            n_xfer++;
            last_data = output_tdata;
            last_user = output_tuser;
            if (exp_q.size() == 0) begin
               check("unexpected_result", 128'({output_tuser, output_tdata}), 128'h1_0000_0000_0000_0000_0000);
            end else begin
               check("scoreboard", 128'({output_tuser, output_tdata}), 128'(exp_q.pop_front()));
            end
         end
         hold_pending = output_tvalid && !output_tready;
         hold_val     = {output_tuser, output_tdata};
         prev_tvalid  = output_tvalid;
      end
   end

   task automatic send_a(input logic [127:0] a, input int gap);
      bit done = 0;
      repeat (gap + 1) @(posedge clk);
      #1;
      input_tdata  = a;
      input_tvalid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (input_tready) begin
            @(posedge clk);
            #1;
            input_tvalid = 1'b0;
            input_tdata  = {$urandom, $urandom, $urandom, $urandom};
            done = 1;
         end
      end
      if (!done) check("send_a_timeout", 128'd0, 128'd1);
   endtask

   task automatic send_m(input logic [63:0] p, input int gap);
      bit done = 0;
      repeat (gap + 1) @(posedge clk);
      #1;
      modulus_tdata  = p;
      modulus_tvalid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (modulus_tready) begin
            @(posedge clk);
            #1;
            modulus_tvalid = 1'b0;
            modulus_tdata  = {$urandom, $urandom};
            done = 1;
         end
      end
      if (!done) check("send_m_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_result(input int start);
      int i = 0;
      while (n_xfer == start && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (n_xfer == start) check("result_timeout", 128'd0, 128'd1);
   endtask

   task automatic run_pair(input logic [127:0] a, input logic [63:0] p, input int ga, input int gm);
      int start = n_xfer;
      exp_q.push_back(model(a, p));
      fork
         send_a(a, ga);
         send_m(p, gm);
      join
      wait_result(start);
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int lat;
      vecs[0] = '{128'd1000, 64'd7, 64'd6, 1'b0, 129};
      vecs[1] = '{128'h1_0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 129};
      vecs[2] = '{{128{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 129};
      vecs[3] = '{128'd5, 64'd0, 64'd0, 1'b1, 1};
      vecs[4] = '{128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D, 64'd1, 64'd0, 1'b0, 129};
      vecs[5] = '{128'd123, 64'd1000, 64'd123, 1'b0, 129};
      vecs[6] = '{128'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 129};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_input_tready", 128'(input_tready), 128'd0);
      check("rst_modulus_tready", 128'(modulus_tready), 128'd0);
      check("rst_tvalid", 128'(output_tvalid), 128'd0);
      check("rst_tdata", 128'(output_tdata), 128'd0);
      check("rst_tuser", 128'(output_tuser), 128'd0);
      rst = 1'b0;
      ready_ctl = 1;
      @(negedge clk);
      check("idle_input_tready", 128'(input_tready), 128'd1);
      check("idle_modulus_tready", 128'(modulus_tready), 128'd1);

      // Directed vector table
      for (int v = 0; v < 7; v++) begin
         run_pair(vecs[v].a, vecs[v].p, 0, 0);
         check($sformatf("vec%0d_data", v), 128'(last_data), 128'(vecs[v].exp_data));
         check($sformatf("vec%0d_user", v), 128'(last_user), 128'(vecs[v].exp_user));
         lat = rise_cyc - ((cap_a_cyc > cap_m_cyc) ? cap_a_cyc : cap_m_cyc);
         check($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
      end

      // Staggered operands, ignored valid pulses while busy, long backpressure
      ready_ctl = 0;
      start = n_xfer;
      exp_q.push_back(model(128'd1000, 64'd7));
      fork
         begin
            send_a(128'd1000, 0);
            @(negedge clk);
            check("t5_a_ready_dropped", 128'(input_tready), 128'd0);
            check("t5_m_ready_still", 128'(modulus_tready), 128'd1);
         end
         send_m(64'd7, 3);
      join
      repeat (5) @(posedge clk);
      #1;
      input_tdata = 128'd999; input_tvalid = 1'b1;
      modulus_tdata = 64'd3;  modulus_tvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      input_tvalid = 1'b0; modulus_tvalid = 1'b0;
      for (int i = 0; i < 300 && !output_tvalid; i++) @(negedge clk);
      check("t5_tvalid_up", 128'(output_tvalid), 128'd1);
      repeat (10) @(negedge clk);
      check("t5_no_early_xfer", 128'(n_xfer - start), 128'd0);
      check("t5_held_data", 128'(output_tdata), 128'd6);
      ready_ctl = 1;
      wait_result(start);
      repeat (5) @(negedge clk);
      check("t5_single_xfer", 128'(n_xfer - start), 128'd1);
      check("t5_data", 128'(last_data), 128'd6);

      // Reset in the middle of a calculation
      exp_q.push_back(model(128'd1000, 64'd7));
      fork
         send_a(128'd1000, 0);
         send_m(64'd7, 0);
      join
      repeat (40) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t6_tvalid", 128'(output_tvalid), 128'd0);
      check("t6_tdata", 128'(output_tdata), 128'd0);
      check("t6_input_tready", 128'(input_tready), 128'd0);
      check("t6_modulus_tready", 128'(modulus_tready), 128'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      start = n_xfer;
      run_pair(128'd12, 64'd5, 0, 0);
      check("t6_after_data", 128'(last_data), 128'd2);
      check("t6_after_count", 128'(n_xfer - start), 128'd1);

      // Random pairs with random valid gaps and random downstream ready
      ready_ctl = 2;
      for (int n = 0; n < 300; n++) begin
         logic [127:0] a;
         logic [63:0]  p;
         int sel = $urandom_range(0, 9);
         a = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = 128'($urandom_range(0, 5000));
         case (sel)
            0:       p = 64'd0;
            1:       p = 64'd1;
            2, 3, 4: p = 64'($urandom_range(2, 1000));
            default: p = {$urandom, $urandom};
         endcase
         run_pair(a, p, $urandom_range(0, 4), $urandom_range(0, 4));
      end

      repeat (5) @(negedge clk);
      check("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
